// File: rtl/period_gen_pkg.sv
// Shared types, default sizes and the config validity check for period_gen.
package period_gen_pkg;

  localparam int unsigned DEF_WIDTH      = 32;
  localparam int unsigned DEF_MIN_PERIOD = 2;
  localparam int unsigned CYC_W          = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  // Fields are zero-extended to 64 bits so one function serves any WIDTH <= 64.
  function automatic logic cfg_valid(input logic [63:0] period,
                                     input logic [63:0] high,
                                     input logic [63:0] min_period);
    return (period >= min_period) && (high >= 64'd1) && (high < period);
  endfunction

endpackage

// File: rtl/period_gen_if.sv
// Config handshake and waveform/status bundle for period_gen.
//   master: offers load_valid/period_in/high_in, observes the generator outputs
//   slave : the generator itself
interface period_gen_if
  import period_gen_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) ();

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] period_in;
  logic [WIDTH-1:0] high_in;
  logic             clk_out;
  logic             period_done;
  logic [CYC_W-1:0] cycles_out;
  logic             cfg_err;
  logic             busy;

  modport master (
    output load_valid, period_in, high_in,
    input  load_ready, clk_out, period_done, cycles_out, cfg_err, busy
  );

  modport slave (
    input  load_valid, period_in, high_in,
    output load_ready, clk_out, period_done, cycles_out, cfg_err, busy
  );

endinterface

// File: rtl/period_gen_cfg.sv
// Config front end: validates offered configs, holds the shadow registers and
// the pending flag, and raises a one-cycle cfg_err for rejected offers.
//   clk, RST          : clock, async active-high reset
//   load_valid_i      : config offer
//   load_ready_i      : generator ready to accept (not powered down)
//   period_i, high_i  : offered config
//   apply_i           : generator is consuming the shadow on this edge
//   shd_period_o/high : shadow config
//   pend_o            : shadow holds a config not yet applied
//   cfg_err_o         : registered pulse, offered config was invalid
module period_gen_cfg
  import period_gen_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned MIN_PERIOD = DEF_MIN_PERIOD
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             load_valid_i,
  input  logic             load_ready_i,
  input  logic [WIDTH-1:0] period_i,
  input  logic [WIDTH-1:0] high_i,
  input  logic             apply_i,
  output logic [WIDTH-1:0] shd_period_o,
  output logic [WIDTH-1:0] shd_high_o,
  output logic             pend_o,
  output logic             cfg_err_o
);

  logic [WIDTH-1:0] shd_period_q, shd_period_d;
  logic [WIDTH-1:0] shd_high_q, shd_high_d;
  logic             pend_q, pend_d;
  logic             cfg_err_q, cfg_err_d;
  logic             accept_c;
  logic             valid_c;

  // Next-state for shadow, pend and error pulse.
  always_comb begin
    shd_period_d = shd_period_q;
    shd_high_d   = shd_high_q;
    pend_d       = pend_q;
    cfg_err_d    = 1'b0;
    accept_c     = load_valid_i & load_ready_i;
    valid_c      = cfg_valid(64'(period_i), 64'(high_i), 64'(MIN_PERIOD));

    // A valid load on an apply edge wins over the clear: the new shadow is
    // left pending for the next apply point.
    if (accept_c && valid_c) begin
      shd_period_d = period_i;
      shd_high_d   = high_i;
      pend_d       = 1'b1;
    end else if (apply_i) begin
      pend_d = 1'b0;
    end

    if (accept_c && !valid_c) begin
      cfg_err_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      shd_period_q <= '0;
      shd_high_q   <= '0;
      pend_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      shd_period_q <= shd_period_d;
      shd_high_q   <= shd_high_d;
      pend_q       <= pend_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign shd_period_o = shd_period_q;
  assign shd_high_o   = shd_high_q;
  assign pend_o       = pend_q;
  assign cfg_err_o    = cfg_err_q;

endmodule

// File: rtl/period_gen.sv
// Programmable period/duty waveform generator.
//   clk    : time base, all outputs registered on its rising edge
//   RST    : async active-high reset
//   PWRDWN : synchronous level, forces the generator idle while high
//   bus    : config handshake (load_*, period_in, high_in) and outputs
//            (clk_out, period_done, cycles_out, cfg_err, busy)
module period_gen
  import period_gen_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned MIN_PERIOD = DEF_MIN_PERIOD
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         PWRDWN,
  period_gen_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;   // active period
  logic [WIDTH-1:0] high_q, high_d;       // active high time
  logic             cfg_ok_q, cfg_ok_d;
  logic [CYC_W-1:0] cycles_q, cycles_d;
  logic             clk_out_q, clk_out_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             apply_c;
  logic [WIDTH-1:0] low_len_c;
  logic [WIDTH-1:0] shd_period;
  logic [WIDTH-1:0] shd_high;
  logic             pend;
  logic             cfg_err;

  assign bus.load_ready = ~PWRDWN;

  period_gen_cfg #(
    .WIDTH      (WIDTH),
    .MIN_PERIOD (MIN_PERIOD)
  ) u_cfg (
    .clk          (clk),
    .RST          (RST),
    .load_valid_i (bus.load_valid),
    .load_ready_i (bus.load_ready),
    .period_i     (bus.period_in),
    .high_i       (bus.high_in),
    .apply_i      (apply_c),
    .shd_period_o (shd_period),
    .shd_high_o   (shd_high),
    .pend_o       (pend),
    .cfg_err_o    (cfg_err)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    high_d    = high_q;
    cfg_ok_d  = cfg_ok_q;
    cycles_d  = cycles_q;
    done_d    = 1'b0;
    apply_c   = 1'b0;
    // Cannot underflow: an applied config always has high < period.
    low_len_c = period_q - high_q;

    if (PWRDWN) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      cycles_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pend || cfg_ok_q) begin
            state_d = ST_HIGH;
            cnt_d   = WIDTH'(1);
            apply_c = pend;
          end
        end
        ST_HIGH: begin
          if (cnt_q == high_q) begin
            state_d = ST_LOW;
            cnt_d   = WIDTH'(1);
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
        ST_LOW: begin
          // Last LOW cycle: period boundary and apply point.
          if (cnt_q == low_len_c) begin
            state_d  = ST_HIGH;
            cnt_d    = WIDTH'(1);
            apply_c  = pend;
            done_d   = 1'b1;
            cycles_d = cycles_q + CYC_W'(1);
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    if (apply_c) begin
      period_d = shd_period;
      high_d   = shd_high;
      cfg_ok_d = 1'b1;
    end

    clk_out_d = (state_d == ST_HIGH);
    busy_d    = (state_d != ST_IDLE);
  end

  // State register; async reset also drops clk_out immediately.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      high_q    <= '0;
      cfg_ok_q  <= 1'b0;
      cycles_q  <= '0;
      clk_out_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      cfg_ok_q  <= cfg_ok_d;
      cycles_q  <= cycles_d;
      clk_out_q <= clk_out_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.clk_out     = clk_out_q;
  assign bus.period_done = done_q;
  assign bus.cycles_out  = cycles_q;
  assign bus.cfg_err     = cfg_err;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_period_gen.sv
// Directed self-checking bench for period_gen.
module tb_period_gen;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic RST;
  logic PWRDWN;
  int   checks = 0;
  int   errors = 0;

  period_gen_if #(.WIDTH(W)) bus ();

  period_gen #(.WIDTH(W), .MIN_PERIOD(2)) dut (
    .clk    (clk),
    .RST    (RST),
    .PWRDWN (PWRDWN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] p, input logic [W-1:0] h);
    bus.load_valid = 1'b1;
    bus.period_in  = p;
    bus.high_in    = h;
    step();
    bus.load_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; PWRDWN = 1'b0;
    bus.load_valid = 1'b0; bus.period_in = '0; bus.high_in = '0;
    #12;
    checks++;
    if ({bus.clk_out, bus.period_done, bus.cfg_err, bus.busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outs: got clk/done/err/busy=%b want 0000",
               {bus.clk_out, bus.period_done, bus.cfg_err, bus.busy});
    end
    checks++;
    if (bus.cycles_out !== 32'd0) begin
      errors++; $display("FAIL reset_cycles: got %0d want 0", bus.cycles_out);
    end
    PWRDWN = 1'b1; #1;
    checks++;
    if (bus.load_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_pd: got %b want 0", bus.load_ready);
    end
    PWRDWN = 1'b0; #1;
    checks++;
    if (bus.load_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", bus.load_ready);
    end
    // Offers made while reset is held must be ignored.
    bus.load_valid = 1'b1; bus.period_in = 32'd5; bus.high_in = 32'd2;
    step(); step();
    bus.load_valid = 1'b0;
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus.clk_out !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_load[%0d]: got clk=%b busy=%b want 0 0", i, bus.clk_out, bus.busy);
      end
    end
  endtask

  task automatic test_invalid();
    logic [W-1:0] pv [3];
    logic [W-1:0] hv [3];
    pv = '{32'd4, 32'd1, 32'd8};
    hv = '{32'd4, 32'd1, 32'd0};
    for (int k = 0; k < 3; k++) begin
      do_load(pv[k], hv[k]);
      checks++;
      if (bus.cfg_err !== 1'b1 || bus.clk_out !== 1'b0) begin
        errors++;
        $display("FAIL invalid_err[%0d]: got err=%b clk=%b want 1 0", k, bus.cfg_err, bus.clk_out);
      end
      step();
      checks++;
      if (bus.cfg_err !== 1'b0 || bus.clk_out !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL invalid_after[%0d]: got err=%b clk=%b busy=%b want 0 0 0",
                 k, bus.cfg_err, bus.clk_out, bus.busy);
      end
    end
  endtask

  task automatic test_basic();
    logic       exp_clk, exp_done;
    int         exp_cyc;
    do_load(32'd5, 32'd2);
    checks++;
    if (bus.clk_out !== 1'b0 || bus.cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_accept: got clk=%b err=%b want 0 0", bus.clk_out, bus.cfg_err);
    end
    exp_cyc = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      exp_clk  = ((i % 5) < 2);
      exp_done = ((i % 5) == 0) && (i > 0);
      if (exp_done) exp_cyc++;
      checks++;
      if (bus.clk_out !== exp_clk || bus.period_done !== exp_done ||
          bus.cycles_out !== 32'(exp_cyc)) begin
        errors++;
        $display("FAIL basic[%0d]: got clk=%b done=%b cyc=%0d want %b %b %0d",
                 i, bus.clk_out, bus.period_done, bus.cycles_out, exp_clk, exp_done, exp_cyc);
      end
    end
    checks++;
    if (bus.cycles_out !== 32'd3) begin
      errors++; $display("FAIL basic_cycles: got %0d want 3", bus.cycles_out);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_clk, exp_done;
    int   j;
    bus.load_valid = 1'b1; bus.period_in = 32'd7; bus.high_in = 32'd2;
    step();
    checks++;
    if (bus.clk_out !== 1'b1) begin
      errors++; $display("FAIL b2b_first: got clk=%b want 1", bus.clk_out);
    end
    bus.period_in = 32'd6; bus.high_in = 32'd3;
    step();
    bus.load_valid = 1'b0;
    checks++;
    if (bus.clk_out !== 1'b0 || bus.period_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got clk=%b done=%b want 0 0", bus.clk_out, bus.period_done);
    end
    for (int i = 0; i < 14; i++) begin
      step();
      if (i < 2) begin
        exp_clk = 1'b0; exp_done = 1'b0;
      end else begin
        j = (i - 2) % 6;
        exp_clk = (j < 3); exp_done = (j == 0);
      end
      checks++;
      if (bus.clk_out !== exp_clk || bus.period_done !== exp_done) begin
        errors++;
        $display("FAIL b2b[%0d]: got clk=%b done=%b want %b %b",
                 i, bus.clk_out, bus.period_done, exp_clk, exp_done);
      end
    end
    checks++;
    if (bus.cycles_out !== 32'd5) begin
      errors++; $display("FAIL b2b_cycles: got %0d want 5", bus.cycles_out);
    end
  endtask

  task automatic test_pwrdwn();
    logic exp_clk, exp_done;
    PWRDWN = 1'b1;
    bus.load_valid = 1'b1; bus.period_in = 32'd1; bus.high_in = 32'd1;
    #1;
    checks++;
    if (bus.load_ready !== 1'b0) begin
      errors++; $display("FAIL pd_ready: got %b want 0", bus.load_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.clk_out !== 1'b0 || bus.busy !== 1'b0 || bus.cycles_out !== 32'd0 ||
          bus.period_done !== 1'b0 || bus.cfg_err !== 1'b0) begin
        errors++;
        $display("FAIL pd_hold[%0d]: got clk=%b busy=%b cyc=%0d done=%b err=%b want 0 0 0 0 0",
                 i, bus.clk_out, bus.busy, bus.cycles_out, bus.period_done, bus.cfg_err);
      end
    end
    bus.load_valid = 1'b0;
    PWRDWN = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      exp_clk  = ((i % 6) < 3);
      exp_done = (i == 6);
      checks++;
      if (bus.clk_out !== exp_clk || bus.period_done !== exp_done ||
          bus.cycles_out !== (exp_done ? 32'd1 : 32'd0)) begin
        errors++;
        $display("FAIL pd_restart[%0d]: got clk=%b done=%b cyc=%0d want %b %b",
                 i, bus.clk_out, bus.period_done, bus.cycles_out, exp_clk, exp_done);
      end
    end
  endtask

  task automatic test_apply_collision();
    logic exp_clk, exp_done;
    int   j;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (bus.clk_out !== (k < 2)) begin
        errors++; $display("FAIL coll_pre[%0d]: got clk=%b want %b", k, bus.clk_out, (k < 2));
      end
    end
    do_load(32'd4, 32'd1);
    checks++;
    if (bus.clk_out !== 1'b1 || bus.period_done !== 1'b1) begin
      errors++;
      $display("FAIL coll_edge: got clk=%b done=%b want 1 1", bus.clk_out, bus.period_done);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      if (i < 5) begin
        exp_clk = (i < 2); exp_done = 1'b0;
      end else begin
        j = (i - 5) % 4;
        exp_clk = (j == 0); exp_done = (j == 0);
      end
      checks++;
      if (bus.clk_out !== exp_clk || bus.period_done !== exp_done) begin
        errors++;
        $display("FAIL coll[%0d]: got clk=%b done=%b want %b %b",
                 i, bus.clk_out, bus.period_done, exp_clk, exp_done);
      end
    end
    checks++;
    if (bus.cycles_out !== 32'd4) begin
      errors++; $display("FAIL coll_cycles: got %0d want 4", bus.cycles_out);
    end
  endtask

  task automatic test_wrap();
    force dut.cycles_q = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (bus.cycles_out !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL wrap_force: got %h want ffffffff", bus.cycles_out);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (bus.clk_out !== 1'b0 || bus.period_done !== 1'b0) begin
        errors++;
        $display("FAIL wrap_low[%0d]: got clk=%b done=%b want 0 0", k, bus.clk_out, bus.period_done);
      end
    end
    release dut.cycles_q;
    step();
    checks++;
    if (bus.cycles_out !== 32'd0 || bus.period_done !== 1'b1 || bus.clk_out !== 1'b1) begin
      errors++;
      $display("FAIL wrap: got cyc=%h done=%b clk=%b want 0 1 1",
               bus.cycles_out, bus.period_done, bus.clk_out);
    end
  endtask

  task automatic test_async_rst();
    logic exp_clk, exp_done;
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if (bus.clk_out !== 1'b0 || bus.busy !== 1'b0 || bus.cycles_out !== 32'd0) begin
      errors++;
      $display("FAIL arst: got clk=%b busy=%b cyc=%0d want 0 0 0", bus.clk_out, bus.busy, bus.cycles_out);
    end
    step();
    RST = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (bus.clk_out !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL arst_idle[%0d]: got clk=%b busy=%b want 0 0", k, bus.clk_out, bus.busy);
      end
    end
    do_load(32'd2, 32'd1);
    checks++;
    if (bus.clk_out !== 1'b0 || bus.cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL arst_load: got clk=%b err=%b want 0 0", bus.clk_out, bus.cfg_err);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      exp_clk  = ((i % 2) == 0);
      exp_done = (i >= 2) && ((i % 2) == 0);
      checks++;
      if (bus.clk_out !== exp_clk || bus.period_done !== exp_done) begin
        errors++;
        $display("FAIL arst_min[%0d]: got clk=%b done=%b want %b %b",
                 i, bus.clk_out, bus.period_done, exp_clk, exp_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_invalid();
    test_basic();
    test_back_to_back();
    test_pwrdwn();
    test_apply_collision();
    test_wrap();
    test_async_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
